calc_ctrl: RTL and testbench

Sequencing controller for the two-operand calculator datapath. It conditions the four raw push buttons into single-cycle commands, steps the user through operand A entry, operand B entry and operation-class selection, then issues the operation to the external ALU over a start/done handshake with a timeout. It presents the nibbles to display (segment decoding is done downstream) and drives the state and class LEDs.

---
 rtl/calc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_calc_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Sequencing controller for the two-operand calculator: debounced button commands,
// operand/class entry FSM, ALU start/done handshake with timeout, display and LED drive.
module calc_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_i,
    input  logic [1:0] sw,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic       alu_start,
    output logic [3:0] opa,
    output logic [3:0] opb,
    output logic [3:0] alu_op,
    output logic [3:0] disp_hi,
    output logic [3:0] disp_lo,
    output logic [3:0] led_light,
    output logic [2:0] led_rgb
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    typedef enum logic [2:0] {ENTER_A, ENTER_B, SEL_OP, EXEC, SHOW, ERR} state_t;

    state_t        state, state_nxt;
    logic [3:0]    sync1, sync2, deb_level, deb_prev, cmd;
    logic [CW-1:0] deb_cnt [4];
    logic [7:0]    result;
    logic [7:0]    timer;
    logic          cmd_clr, cmd_next, cmd_dec, cmd_inc;
    logic          done_ok, timed_out;

    function automatic logic [3:0] light_of(input state_t s);
        case (s)
            ENTER_A: return 4'b0001;
            ENTER_B: return 4'b0011;
            SEL_OP:  return 4'b0111;
            EXEC:    return 4'b1111;
            SHOW:    return 4'b1111;
            ERR:     return 4'b1001;
            default: return 4'b0001;
        endcase
    endfunction

    // Button front end: 2-flop sync, stable-level counter, registered rising-edge pulse.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops see pre-edge values.
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb_level <= '0;
            deb_prev  <= '0;
            cmd       <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync1    <= btn_i;
            sync2    <= sync1;
            deb_prev <= deb_level;
            cmd      <= deb_level & ~deb_prev;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_level[i] <= sync2[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign cmd_clr  = cmd[3];
    assign cmd_next = cmd[2] & ~cmd[3];
    assign cmd_dec  = cmd[1] & ~(|cmd[3:2]);
    assign cmd_inc  = cmd[0] & ~(|cmd[3:1]);

    // A done coincident with alu_start (first EXEC cycle) is not accepted.
    assign done_ok   = (state == EXEC) && alu_done && !alu_start;
    assign timed_out = (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ENTER_A;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        if (cmd_clr) begin
            state_nxt = ENTER_A;
        end else begin
            case (state)
                ENTER_A: if (cmd_next) state_nxt = ENTER_B;
                ENTER_B: if (cmd_next) state_nxt = SEL_OP;
                SEL_OP:  if (cmd_next || cmd_dec || cmd_inc) state_nxt = EXEC;
                EXEC: begin
                    if (done_ok)        state_nxt = SHOW;
                    else if (timed_out) state_nxt = ERR;
                end
                SHOW:    if (cmd_next) state_nxt = ENTER_A;
                ERR:     if (cmd_next) state_nxt = ENTER_A;
                default: state_nxt = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            alu_op    <= '0;
            result    <= '0;
            timer     <= '0;
            alu_start <= 1'b0;
            led_light <= 4'b0001;
            led_rgb   <= '0;
        end else begin
            led_light <= light_of(state_nxt);
            alu_start <= (state_nxt == EXEC) && (state != EXEC);
            timer     <= (state == EXEC && state_nxt == EXEC) ? timer + 8'd1 : 8'd0;
            if (cmd_clr) begin
                opa     <= '0;
                opb     <= '0;
                alu_op  <= '0;
                led_rgb <= '0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (cmd_inc)      opa <= opa + 4'd1;
                        else if (cmd_dec) opa <= opa - 4'd1;
                    end
                    ENTER_B: begin
                        if (cmd_inc)      opb <= opb + 4'd1;
                        else if (cmd_dec) opb <= opb - 4'd1;
                    end
                    SEL_OP: begin
                        if (cmd_next) begin
                            alu_op  <= {2'b01, sw};
                            led_rgb <= 3'b001;
                        end else if (cmd_dec) begin
                            alu_op  <= {2'b10, sw};
                            led_rgb <= 3'b010;
                        end else if (cmd_inc) begin
                            alu_op  <= {2'b11, sw};
                            led_rgb <= 3'b100;
                        end
                    end
                    EXEC: if (done_ok) result <= alu_result;
                    SHOW: begin
                        if (cmd_next) begin
                            opa <= result[3:0];
                            opb <= '0;
                        end
                    end
                    ERR: begin
                        if (cmd_next) begin
                            opa     <= '0;
                            opb     <= '0;
                            alu_op  <= '0;
                            led_rgb <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        disp_hi = opa;
        disp_lo = opb;
        case (state)
            SHOW: begin
                disp_hi = result[7:4];
                disp_lo = result[3:0];
            end
            ERR: begin
                disp_hi = 4'hE;
                disp_lo = 4'hE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: button entry, wrap, ALU handshake, timeout,
// clear priority, glitch rejection, chaining and mid-EXEC reset.
module tb_calc_ctrl;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [1:0] sw = 2'b00;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_start;
    logic [3:0] opa, opb, alu_op, disp_hi, disp_lo, led_light;
    logic [2:0] led_rgb;

    int n_tests = 0;
    int n_fail  = 0;
    bit seen;

    calc_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_i      (btn),
        .sw         (sw),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_start  (alu_start),
        .opa        (opa),
        .opb        (opb),
        .alu_op     (alu_op),
        .disp_hi    (disp_hi),
        .disp_lo    (disp_lo),
        .led_light  (led_light),
        .led_rgb    (led_rgb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (DEB + 4) tick();
        btn[idx] = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 3 * DEB && !found; i++) begin
            tick();
            if (alu_start === 1'b1) found = 1'b1;
        end
        check("alu_start_seen", 32'(found), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with inc held: values at reset, then full debounce after release.
        btn = 4'b0001;
        repeat (3) tick();
        check("rst_led_light", 32'(led_light), 32'h1);
        check("rst_opa", 32'(opa), 32'h0);
        check("rst_opb", 32'(opb), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_led_rgb", 32'(led_rgb), 32'h0);
        check("rst_alu_start", 32'(alu_start), 32'h0);
        check("rst_disp_hi", 32'(disp_hi), 32'h0);
        check("rst_disp_lo", 32'(disp_lo), 32'h0);
        rst = 1'b0;
        repeat (DEB + 3) tick();
        check("deb_latency_early", 32'(opa), 32'h0);
        tick();
        check("deb_latency_exact", 32'(opa), 32'h1);
        btn = 4'b0000;
        repeat (DEB + 4) tick();

        // Increments to 3, then dec x4 wraps through 0 to 15.
        press(0);
        press(0);
        check("inc_opa3", 32'(opa), 32'h3);
        check("inc_disp_hi3", 32'(disp_hi), 32'h3);
        for (int i = 0; i < 4; i++) press(1);
        check("dec_wrap_opa", 32'(opa), 32'hF);
        check("dec_wrap_disp", 32'(disp_hi), 32'hF);

        // A=5, B=3, arith class with sw=00; done 3 cycles after start.
        press(3);
        check("clear_opa", 32'(opa), 32'h0);
        for (int i = 0; i < 5; i++) press(0);
        press(2);
        check("enter_b_led", 32'(led_light), 32'h3);
        for (int i = 0; i < 3; i++) press(0);
        check("opb3_disp_lo", 32'(disp_lo), 32'h3);
        press(2);
        check("sel_op_led", 32'(led_light), 32'h7);
        sw = 2'b00;
        btn[2] = 1'b1;
        wait_start(seen);
        check("arith_alu_op", 32'(alu_op), 32'h4);
        check("arith_rgb", 32'(led_rgb), 32'h1);
        check("exec_led", 32'(led_light), 32'hF);
        alu_done = 1'b1;                    // coincident with start: must be ignored
        alu_result = 8'h77;
        tick();
        alu_done = 1'b0;
        check("start_one_cycle", 32'(alu_start), 32'h0);
        check("early_done_ignored_hi", 32'(disp_hi), 32'h5);
        check("early_done_ignored_lo", 32'(disp_lo), 32'h3);
        tick();
        tick();
        alu_done = 1'b1;
        alu_result = 8'h08;
        tick();
        alu_done = 1'b0;
        check("show_disp_hi", 32'(disp_hi), 32'h0);
        check("show_disp_lo", 32'(disp_lo), 32'h8);
        check("show_led", 32'(led_light), 32'hF);
        check("show_rgb", 32'(led_rgb), 32'h1);
        btn[2] = 1'b0;
        repeat (DEB + 4) tick();
        alu_done = 1'b1;                    // stray done in SHOW
        alu_result = 8'hFF;
        tick();
        alu_done = 1'b0;
        tick();
        check("stray_show_hi", 32'(disp_hi), 32'h0);
        check("stray_show_lo", 32'(disp_lo), 32'h8);
        press(2);
        check("chain1_opa", 32'(opa), 32'h8);
        check("chain1_opb", 32'(opb), 32'h0);
        check("chain1_led", 32'(led_light), 32'h1);

        // Timeout: no done for 255 EXEC cycles.
        press(2);
        press(2);
        btn[2] = 1'b1;
        wait_start(seen);
        repeat (254) tick();
        check("tmo_not_yet", 32'(led_light), 32'hF);
        tick();
        check("tmo_err_led", 32'(led_light), 32'h9);
        check("tmo_disp_hi", 32'(disp_hi), 32'hE);
        check("tmo_disp_lo", 32'(disp_lo), 32'hE);
        btn[2] = 1'b0;
        repeat (DEB + 4) tick();
        press(2);
        check("err_exit_led", 32'(led_light), 32'h1);
        check("err_exit_opa", 32'(opa), 32'h0);
        check("err_exit_opb", 32'(opb), 32'h0);
        check("err_exit_rgb", 32'(led_rgb), 32'h0);
        check("err_exit_alu_op", 32'(alu_op), 32'h0);

        // Clear + inc + next together in ENTER_B: only clear acts.
        press(0);
        press(0);
        press(2);
        for (int i = 0; i < 7; i++) press(0);
        check("prio_opb7", 32'(opb), 32'h7);
        btn = 4'b1101;
        repeat (DEB + 4) tick();
        btn = 4'b0000;
        repeat (DEB + 4) tick();
        check("prio_led", 32'(led_light), 32'h1);
        check("prio_opa", 32'(opa), 32'h0);
        check("prio_opb", 32'(opb), 32'h0);

        // Short glitch rejected; long hold gives exactly one increment.
        btn[0] = 1'b1;
        repeat (5) tick();
        btn[0] = 1'b0;
        repeat (2 * DEB) tick();
        check("glitch_opa", 32'(opa), 32'h0);
        btn[0] = 1'b1;
        repeat (100) tick();
        btn[0] = 1'b0;
        repeat (DEB + 4) tick();
        check("hold_one_inc", 32'(opa), 32'h1);

        // Logic class with sw=10, result 2C, then chaining opa=C.
        press(0);
        press(2);
        press(1);
        check("opb_wrap_disp", 32'(disp_lo), 32'hF);
        press(2);
        sw = 2'b10;
        btn[1] = 1'b1;
        wait_start(seen);
        check("logic_alu_op", 32'(alu_op), 32'hA);
        check("logic_rgb", 32'(led_rgb), 32'h2);
        sw = 2'b01;
        tick();
        tick();
        alu_done = 1'b1;
        alu_result = 8'h2C;
        tick();
        alu_done = 1'b0;
        check("show2c_hi", 32'(disp_hi), 32'h2);
        check("show2c_lo", 32'(disp_lo), 32'hC);
        check("sw_after_sel", 32'(alu_op), 32'hA);
        btn[1] = 1'b0;
        repeat (DEB + 4) tick();
        press(2);
        check("chain2_opa", 32'(opa), 32'hC);
        check("chain2_opb", 32'(opb), 32'h0);
        check("chain2_led", 32'(led_light), 32'h1);
        alu_done = 1'b1;                    // stray done in ENTER_A
        alu_result = 8'h55;
        tick();
        alu_done = 1'b0;
        tick();
        check("stray_a_hi", 32'(disp_hi), 32'hC);
        check("stray_a_lo", 32'(disp_lo), 32'h0);
        check("stray_a_led", 32'(led_light), 32'h1);

        // Shift class, then reset asserted in the first EXEC cycle.
        press(2);
        press(2);
        btn[0] = 1'b1;
        wait_start(seen);
        check("shift_rgb", 32'(led_rgb), 32'h4);
        check("shift_alu_op", 32'(alu_op), 32'hD);
        btn = 4'b0000;
        rst = 1'b1;
        tick();
        check("midrst_start", 32'(alu_start), 32'h0);
        check("midrst_led", 32'(led_light), 32'h1);
        check("midrst_opa", 32'(opa), 32'h0);
        check("midrst_alu_op", 32'(alu_op), 32'h0);
        check("midrst_rgb", 32'(led_rgb), 32'h0);
        check("midrst_disp_hi", 32'(disp_hi), 32'h0);
        rst = 1'b0;
        repeat (DEB + 4) tick();
        check("post_rst_idle", 32'(led_light), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
